sram_apb: RTL and testbench

APB-attached, parametrised single-port SRAM with a registered response FSM: configurable data width, depth and wait states, byte strobes, out-of-range error responses, and optional two-phase misaligned access. It is the next-generation program/data memory behind the core's APB bridge, with an error path and deterministic latency.

---
 rtl/sram_apb.sv | 196 +++++++++++++++++++
 tb/tb_sram_apb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sram_apb.sv
// APB-attached single-port SRAM with byte strobes, range errors and fixed-latency response FSM.
// Define SRAM_MISALIGN_EN to build two-phase word-crossing accesses; otherwise misaligned accesses error.
module sram_apb #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 262144,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pdata,
  output logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH/8-1:0] pstb,
  output logic                    pready,
  output logic                    perr
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned WW = ADDR_WIDTH - OW;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, PH1, PH2, RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [MW-1:0]         word_q, word_d;
  logic [OW-1:0]         off_q, off_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NB-1:0]         stb_q, stb_d;

  logic                  active;
  logic [WW-1:0]         a_word;
  logic [OW-1:0]         a_off;
  logic                  a_err;
  logic                  phase_en, phase_hi;
  logic [MW-1:0]         mem_idx;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] rd_word;

  // Access byte index carried by memory lane l for a start offset o.
  function automatic logic [OW-1:0] lane_byte(input int l, input logic [OW-1:0] o);
    return OW'(l) - o;
  endfunction

  assign active = psel && penable;
  assign a_word = paddr[ADDR_WIDTH-1:OW];
  assign a_off  = paddr[OW-1:0];

`ifdef SRAM_MISALIGN_EN
  // A crossing access must also have its second word in range; no wrap to word 0.
  assign a_err = (64'(a_word) >= 64'(DEPTH)) ||
                 ((a_off != '0) && (64'(a_word) + 64'd1 >= 64'(DEPTH)));
`else
  assign a_err = (64'(a_word) >= 64'(DEPTH)) || (a_off != '0);
`endif

  assign prdata = prdata_q;
  assign pready = pready_q;
  assign perr   = perr_q;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      perr_q   <= 1'b0;
      prdata_q <= '0;
      word_q   <= '0;
      off_q    <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
      stb_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      perr_q   <= perr_d;
      prdata_q <= prdata_d;
      word_q   <= word_d;
      off_q    <= off_d;
      write_q  <= write_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    perr_d   = 1'b0;
    prdata_d = prdata_q;
    word_d   = word_q;
    off_d    = off_q;
    write_d  = write_q;
    data_d   = data_q;
    stb_d    = stb_q;
    phase_en = 1'b0;
    phase_hi = 1'b0;
    mem_be   = '0;
    mem_wd   = '0;

    unique case (state_q)
      IDLE: begin
        if (active) begin
          write_d = pwrite;
          data_d  = pdata;
          stb_d   = pstb;
          off_d   = a_off;
          cnt_d   = '0;
          if (a_err) begin
            state_d  = RESP;
            pready_d = 1'b1;
            perr_d   = 1'b1;
            if (!pwrite) prdata_d = '0;
          end else begin
            word_d  = MW'(a_word);
            state_d = (WAIT_STATES > 0) ? WAIT : PH1;
          end
        end
      end
      WAIT: begin
        if (!active) state_d = IDLE;
        else if (cnt_q == 4'(WAIT_STATES - 1)) state_d = PH1;
        else cnt_d = cnt_q + 4'd1;
      end
      PH1: begin
        if (!active) begin
          state_d = IDLE;
        end else begin
          phase_en = 1'b1;
`ifdef SRAM_MISALIGN_EN
          if (off_q != '0) begin
            state_d = PH2;
          end else begin
            state_d  = RESP;
            pready_d = 1'b1;
          end
`else
          state_d  = RESP;
          pready_d = 1'b1;
`endif
        end
      end
`ifdef SRAM_MISALIGN_EN
      PH2: begin
        if (!active) begin
          state_d = IDLE;
        end else begin
          phase_en = 1'b1;
          phase_hi = 1'b1;
          state_d  = RESP;
          pready_d = 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_idx = phase_hi ? (word_q + MW'(1)) : word_q;
    rd_word = mem[mem_idx];

    // PH1 owns lanes at or above the offset in word w; PH2 owns the lanes below it in word w+1.
    for (int l = 0; l < NB; l++) begin
      if (phase_en && (phase_hi ? (OW'(l) < off_q) : (OW'(l) >= off_q))) begin
        if (write_q) begin
          mem_be[l]          = stb_q[lane_byte(l, off_q)];
          mem_wd[8*l +: 8]   = data_q[8*lane_byte(l, off_q) +: 8];
        end else begin
          prdata_d[8*lane_byte(l, off_q) +: 8] = rd_word[8*l +: 8];
        end
      end
    end
  end

  // Memory array has no reset.
  always_ff @(posedge pclk) begin
    for (int l = 0; l < NB; l++) begin
      if (mem_be[l]) mem[mem_idx][8*l +: 8] <= mem_wd[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_sram_apb.sv
// Directed bench for sram_apb: DEPTH=16 instance with no wait states and one with three.
// Expectations follow SRAM_MISALIGN_EN when it is defined for the build.
module tb_sram_apb;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pdata = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  pstb = '0;
  logic        use_wait = 1'b0;

  logic [31:0] prdata0, prdata1, prdata;
  logic        pready0, pready1, pready;
  logic        perr0, perr1, perr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  sram_apb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pdata(pdata), .prdata(prdata0),
    .psel(psel & ~use_wait), .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready0), .perr(perr0)
  );

  sram_apb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) u_wait (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pdata(pdata), .prdata(prdata1),
    .psel(psel & use_wait), .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready1), .perr(perr1)
  );

  assign prdata = use_wait ? prdata1 : prdata0;
  assign pready = use_wait ? pready1 : pready0;
  assign perr   = use_wait ? perr1   : perr0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer; lat counts cycles after cycle A until pready (0 if it never came).
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] stb, output logic [31:0] rd, output logic err,
                     output int lat);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = wd; pstb = stb;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge pclk); #1;
      if (pready) begin
        lat = n; rd = prdata; err = perr;
        break;
      end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] stb,
                          input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic err; int lat;
    apb(1'b1, addr, wd, stb, rd, err, lat);
    check($sformatf("wr_lat@%0h", addr), 32'(lat), 32'(exp_lat));
    check($sformatf("wr_err@%0h", addr), 32'(err), 32'(exp_err));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic err; int lat;
    apb(1'b0, addr, '0, 4'hF, rd, err, lat);
    check($sformatf("rd_lat@%0h", addr), 32'(lat), 32'(exp_lat));
    check($sformatf("rd_err@%0h", addr), 32'(err), 32'(exp_err));
    check($sformatf("rd_data@%0h", addr), rd, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic err; int lat;

    #2 prst = 1'b1;
    #1;
    check("rst_pready", 32'(pready0), 32'd0);
    check("rst_perr", 32'(perr0), 32'd0);
    check("rst_prdata", prdata0, 32'd0);
    check("rst_pready_w", 32'(pready1), 32'd0);
    @(negedge pclk); @(negedge pclk);
    prst = 1'b0;

    // Aligned, strobed and empty-strobe writes.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 2);
    do_read (32'h10, 32'hDEADBEEF, 1'b0, 2);
    do_write(32'h10, 32'h11223344, 4'b0101, 1'b0, 2);
    do_read (32'h10, 32'hDE22BE44, 1'b0, 2);
    do_write(32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 2);
    do_read (32'h10, 32'hDE22BE44, 1'b0, 2);

    // Word-crossing access at 0x13.
    do_write(32'h14, 32'h00000000, 4'hF, 1'b0, 2);
`ifdef SRAM_MISALIGN_EN
    do_write(32'h13, 32'hAABBCCDD, 4'hF, 1'b0, 3);
    do_read (32'h14, 32'h00AABBCC, 1'b0, 2);
    do_read (32'h10, 32'hDD22BE44, 1'b0, 2);
    do_read (32'h13, 32'hAABBCCDD, 1'b0, 3);
`else
    do_write(32'h13, 32'hAABBCCDD, 4'hF, 1'b1, 1);
    do_read (32'h14, 32'h00000000, 1'b0, 2);
    do_read (32'h10, 32'hDE22BE44, 1'b0, 2);
    do_read (32'h13, 32'h00000000, 1'b1, 1);
`endif

    // Range errors at the top of a 16-word memory.
    do_write(32'h3C, 32'h12345678, 4'hF, 1'b0, 2);
    do_write(32'h00, 32'hCAFEF00D, 4'hF, 1'b0, 2);
    do_read (32'h3C, 32'h12345678, 1'b0, 2);
    apb(1'b1, 32'h3D, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    check("wr3d_lat", 32'(lat), 32'd1);
    check("wr3d_err", 32'(err), 32'd1);
    check("wr3d_prdata_kept", rd, 32'h12345678);
    do_read (32'h3C, 32'h12345678, 1'b0, 2);
    do_read (32'h00, 32'hCAFEF00D, 1'b0, 2);
    do_read (32'h40, 32'h00000000, 1'b1, 1);

    // Reset asserted mid-transfer.
    do_write(32'h18, 32'h00000000, 4'hF, 1'b0, 2);
    do_write(32'h1C, 32'h00000000, 4'hF, 1'b0, 2);
    do_read (32'h00, 32'hCAFEF00D, 1'b0, 2);
    @(negedge pclk);
`ifdef SRAM_MISALIGN_EN
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1B; pdata = 32'h55667788; pstb = 4'hF;
    @(negedge pclk); penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("ph2_pready_before_rst", 32'(pready0), 32'd0);
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    check("midrst_pready", 32'(pready0), 32'd0);
    check("midrst_perr", 32'(perr0), 32'd0);
    check("midrst_prdata", prdata0, 32'd0);
    @(negedge pclk); prst = 1'b0;
    do_read(32'h18, 32'h88000000, 1'b0, 2);
    do_read(32'h1C, 32'h00000000, 1'b0, 2);
`else
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pdata = 32'h99999999; pstb = 4'hF;
    @(negedge pclk); penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    check("midrst_pready", 32'(pready0), 32'd0);
    check("midrst_perr", 32'(perr0), 32'd0);
    check("midrst_prdata", prdata0, 32'd0);
    @(negedge pclk); prst = 1'b0;
    do_read(32'h18, 32'h00000000, 1'b0, 2);
`endif

    // Three wait states: latency and abort.
    use_wait = 1'b1;
    do_write(32'h20, 32'h0BADCAFE, 4'hF, 1'b0, 5);
    do_read (32'h20, 32'h0BADCAFE, 1'b0, 5);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pstb = 4'hF;
    @(negedge pclk); penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge pclk); #1;
      check($sformatf("abort_pready_c%0d", c), 32'(pready1), 32'd0);
    end
    do_read (32'h20, 32'h0BADCAFE, 1'b0, 5);
    do_read (32'h40, 32'h00000000, 1'b1, 1);
    use_wait = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
